timer: RTL and testbench



---
 rtl/timer.sv | 51 +++++
 tb/tb_timer.sv | 94 +++++++++
 2 files changed

// File: rtl/timer.sv
// Free-running divider: ClkOut is a 50 % (or ceil/floor for odd D) timebase of
// period D Clk cycles. A short divisor is selected when SIMULATION is defined.
`timescale 1ns/100ps
module timer #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int OUT_HZ      = 1,
    parameter int SIM_DIVISOR = 100
) (
    input  logic Clk,
    input  logic Reset,
    output logic ClkOut
);

`ifdef SIMULATION
    localparam int D = SIM_DIVISOR;
`else
    localparam int D = CLK_HZ / OUT_HZ;
`endif

    localparam int H_HI = (D + 1) / 2;
    localparam int H_LO = D / 2;
    localparam int CW   = (H_HI > 1) ? $clog2(H_HI) : 1;

    localparam logic [CW-1:0] LIM_HI = CW'(H_HI - 1);
    localparam logic [CW-1:0] LIM_LO = CW'(H_LO - 1);

    generate
        if (D < 2) begin : g_bad_divisor
            $error("timer: divisor %0d is below the minimum of 2", D);
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic [CW-1:0] lim;

    // Odd divisors put the extra cycle in the high phase.
    assign lim = ClkOut ? LIM_HI : LIM_LO;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt    <= '0;
            ClkOut <= 1'b0;
        end else if (cnt == lim) begin
            cnt    <= '0;
            ClkOut <= ~ClkOut;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_timer.sv
// Directed bench for timer: D = 100, 7 and 2 instances share Clk and Reset.
`timescale 1ns/100ps
module tb_timer;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    logic out100, out7, out2;

    int checks = 0;
    int errors = 0;

    // Parameter pairs chosen so the effective divisor is identical with or
    // without SIMULATION defined.
    timer #(.CLK_HZ(1000), .OUT_HZ(10), .SIM_DIVISOR(100)) u_d100 (
        .Clk(Clk), .Reset(Reset), .ClkOut(out100));
    timer #(.CLK_HZ(7), .OUT_HZ(1), .SIM_DIVISOR(7)) u_d7 (
        .Clk(Clk), .Reset(Reset), .ClkOut(out7));
    timer #(.CLK_HZ(2), .OUT_HZ(1), .SIM_DIVISOR(2)) u_d2 (
        .Clk(Clk), .Reset(Reset), .ClkOut(out2));

    always #1 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // After n rising edges since release, ClkOut is high once n mod D >= floor(D/2).
    function automatic logic exp_out(input int n, input int d);
        return ((n % d) >= (d / 2));
    endfunction

    function automatic int exp_cnt(input int n, input int d);
        int p;
        p = n % d;
        return (p < d / 2) ? p : p - d / 2;
    endfunction

    task automatic run_edges(input int first, input int last);
        for (int n = first; n <= last; n++) begin
            @(negedge Clk);
            chk($sformatf("d100_out_e%0d", n), 32'(out100), 32'(exp_out(n, 100)));
            chk($sformatf("d100_cnt_e%0d", n), 32'(u_d100.cnt), 32'(exp_cnt(n, 100)));
            chk($sformatf("d7_out_e%0d", n), 32'(out7), 32'(exp_out(n, 7)));
            chk($sformatf("d2_out_e%0d", n), 32'(out2), 32'(exp_out(n, 2)));
        end
    endtask

    initial begin
        // Reset hold with the clock running
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("rst_d100_out", 32'(out100), 32'd0);
            chk("rst_d100_cnt", 32'(u_d100.cnt), 32'd0);
            chk("rst_d7_out", 32'(out7), 32'd0);
            chk("rst_d2_out", 32'(out2), 32'd0);
        end

        // Release between edges; the next posedge is edge 1 of the low phase.
        Reset = 1'b1;
        run_edges(1, 1000);

        // Move 20 cycles into a high phase (high starts at edge 1050).
        run_edges(1001, 1070);
        chk("mid_pre_high", 32'(out100), 32'd1);

        // Async clear: no Clk edge between assertion and the check.
        Reset = 1'b0;
        #0.2;
        chk("mid_async_d100", 32'(out100), 32'd0);
        chk("mid_async_cnt", 32'(u_d100.cnt), 32'd0);
        chk("mid_async_d7", 32'(out7), 32'd0);
        repeat (3) @(negedge Clk);
        chk("mid_hold_d100", 32'(out100), 32'd0);

        Reset = 1'b1;
        run_edges(1, 120);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: bench did not complete within 100000 ns");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
